// File: rtl/rx_seq_pkg.sv
// rx_seq_pkg: shared states, status codes and CRC-16/CCITT constants for rx_seq_ctrl.
package rx_seq_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_PRE, RECV, DONE} state_e;
  typedef enum logic [1:0] {ERR_OK, ERR_NOPRE, ERR_GAP, ERR_ABORT} err_e;
  localparam logic [15:0] POLY    = 16'h1021;
  localparam logic [15:0] PRESET  = 16'hFFFF;
  localparam logic [15:0] RESIDUE = 16'h1D0F;
endpackage

// File: rtl/crc16_serial.sv
// crc16_serial: bit-serial CRC-16/CCITT, MSB first, preset on clr.
module crc16_serial
  import rx_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= PRESET;
    else if (clr) crc <= PRESET;
    else if (en) crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? POLY : 16'h0000);
endmodule

// File: rtl/rx_seq_ctrl.sv
// rx_seq_ctrl: sequences RX chain reset, preamble wait, bit forwarding and status for one reply.
// Optional RX_SEQ_CRC16_EN adds CRC-16 residue checking and the crc_ok output.
module rx_seq_ctrl
  import rx_seq_pkg::*;
#(
  parameter int MAX_BITS   = 512,
  parameter int RST_CYCLES = 4,
  parameter int T1_CYCLES  = 4000,
  parameter int GAP_CYCLES = 400,
  localparam int LEN_W = $clog2(MAX_BITS + 1),
  localparam int TO_W  = $clog2(T1_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] exp_bits,
  output logic             rx_rst,
  output logic             rx_en,
  input  logic             pre_det,
  input  logic             bit_dat,
  input  logic             bit_vld,
  output logic             out_dat,
  output logic             out_vld,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
`ifdef RX_SEQ_CRC16_EN
  ,
  output logic             crc_ok
`endif
);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_BITS);
  localparam logic [TO_W-1:0]  ARM_END = TO_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  T1_END  = TO_W'(T1_CYCLES - 1);
  localparam logic [TO_W-1:0]  GAP_END = TO_W'(GAP_CYCLES - 1);
  state_e state_q, state_d;
  err_e err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic fwd, last_d, active;
  assign active = state_q == ARM || state_q == WAIT_PRE || state_q == RECV;
  // to_q is shared: arm length, preamble timeout and inter-bit gap
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    len_d = len_q;
    cnt_d = cnt_q;
    to_d = '0;
    fwd = 1'b0;
    last_d = 1'b0;
    case (state_q)
      IDLE: if (start && exp_bits != '0 && exp_bits <= MAX_L) begin
        state_d = ARM;
        len_d = exp_bits;
        cnt_d = '0;
      end
      ARM: begin
        to_d = to_q + 1'b1;
        if (to_q >= ARM_END) begin
          state_d = WAIT_PRE;
          to_d = '0;
        end
      end
      WAIT_PRE: begin
        to_d = to_q + 1'b1;
        if (pre_det) begin
          state_d = RECV;
          cnt_d = '0;
          to_d = '0;
        end else if (to_q >= T1_END) begin
          state_d = DONE;
          err_d = ERR_NOPRE;
        end
      end
      RECV: begin
        to_d = to_q + 1'b1;
        if (bit_vld) begin
          fwd = 1'b1;
          cnt_d = cnt_q + 1'b1;
          to_d = '0;
          if (cnt_d >= len_q) begin
            last_d = 1'b1;
            state_d = DONE;
            err_d = ERR_OK;
          end
        end else if (to_q >= GAP_END) begin
          state_d = DONE;
          err_d = ERR_GAP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && active) begin
      state_d = DONE;
      err_d = ERR_ABORT;
      fwd = 1'b0;
      last_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      err_q <= ERR_OK;
      len_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      out_vld <= 1'b0;
      out_dat <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      out_vld <= fwd;
      out_dat <= fwd ? bit_dat : out_dat;
      out_last <= last_d;
    end
  assign rx_rst = state_q == ARM;
  assign rx_en = state_q == WAIT_PRE || state_q == RECV;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
`ifdef RX_SEQ_CRC16_EN
  logic [15:0] crc;
  crc16_serial u_crc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state_q == IDLE),
    .en(fwd),
    .din(bit_dat),
    .crc(crc)
  );
  // a completed reply with a bad residue is reported as err 3
  assign err = done ? ((err_q == ERR_OK && crc != RESIDUE) ? ERR_ABORT : err_q) : ERR_OK;
  assign crc_ok = done && err_q == ERR_OK && crc == RESIDUE;
`else
  assign err = done ? err_q : ERR_OK;
`endif
endmodule

// File: tb/tb_rx_seq_ctrl.sv
// tb_rx_seq_ctrl: directed self-checking bench for rx_seq_ctrl (default params, optional RX_SEQ_CRC16_EN).
module tb_rx_seq_ctrl;
  logic clk, rst_n, start, abort, pre_det, bit_dat, bit_vld;
  logic [9:0] exp_bits;
  logic rx_rst, rx_en, out_dat, out_vld, out_last, busy, done;
  logic [1:0] err;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, nvld = 0, nlast = 0, ndone = 0, nrst = 0;
  int b_vld, b_last, b_done, b_rst;
  int last_idx, last_vld_cyc, en_cyc, dcyc;
  logic en_seen, prev_done, busy_after, en_at_done, dcrc;
  logic [1:0] derr;
  logic [31:0] word;
`ifdef RX_SEQ_CRC16_EN
  logic crc_ok;
  localparam logic [1:0] NOM_ERR = 2'd3;
`else
  localparam logic [1:0] NOM_ERR = 2'd0;
`endif
  rx_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_bits(exp_bits),
    .rx_rst(rx_rst), .rx_en(rx_en), .pre_det(pre_det), .bit_dat(bit_dat), .bit_vld(bit_vld),
    .out_dat(out_dat), .out_vld(out_vld), .out_last(out_last), .busy(busy), .done(done),
    .err(err)
`ifdef RX_SEQ_CRC16_EN
    , .crc_ok(crc_ok)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (out_vld) begin nvld++; word = {word[30:0], out_dat}; last_vld_cyc = cyc; end
    if (out_last) begin nlast++; last_idx = nvld; end
    if (rx_rst) nrst++;
    if (rx_en && !en_seen) begin en_seen = 1'b1; en_cyc = cyc; end
    if (prev_done) busy_after = busy;
    prev_done = done;
    if (done) begin
      ndone++; derr = err; dcyc = cyc; en_at_done = rx_en;
`ifdef RX_SEQ_CRC16_EN
      dcrc = crc_ok;
`endif
    end
  endtask
  task automatic start_cap(input logic [9:0] n);
    b_vld = nvld; b_last = nlast; b_done = ndone; b_rst = nrst; en_seen = 1'b0; busy_after = 1'bx;
    start = 1'b1; exp_bits = n;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_en();
    for (int k = 0; k < 20 && !en_seen; k++) tick();
  endtask
  task automatic preamble(input int dly);
    repeat (dly) tick();
    pre_det = 1'b1;
    tick();
    pre_det = 1'b0;
  endtask
  task automatic send(input int n, input logic [31:0] data, input int sp);
    for (int i = n - 1; i >= 0; i--) begin
      bit_vld = 1'b1; bit_dat = data[i];
      tick();
      bit_vld = 1'b0;
      repeat (sp - 1) tick();
    end
  endtask
  task automatic wait_done(input int max);
    for (int k = 0; k < max && ndone == b_done; k++) tick();
    tick();
  endtask
  task automatic run_nominal(input string tag);
    start_cap(10'd16);
    wait_en();
    preamble(99);
    send(16, 32'h0000_A5C3, 22);
    wait_done(100);
    check({tag, "_vld"}, nvld - b_vld, 16);
    check({tag, "_last"}, nlast - b_last, 1);
    check({tag, "_last_idx"}, last_idx - b_vld, 16);
    check({tag, "_data"}, {16'h0, word[15:0]}, 32'hA5C3);
    check({tag, "_done"}, ndone - b_done, 1);
    check({tag, "_err"}, derr, NOM_ERR);
    check({tag, "_busy_after"}, busy_after, 0);
    check({tag, "_rx_rst_len"}, nrst - b_rst, 4);
  endtask
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction
  initial begin
    logic [15:0] c;
    logic [31:0] data;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pre_det = 1'b0; bit_dat = 1'b0; bit_vld = 1'b0;
    exp_bits = '0; word = '0; en_seen = 1'b0; prev_done = 1'b0; dcrc = 1'b0;
    repeat (3) tick();
    check("rst_outs", {rx_rst, rx_en, out_dat, out_vld, out_last, busy, done, err}, 0);
    rst_n = 1'b1;
    tick();
    start = 1'b1; exp_bits = 10'd0; tick(); start = 1'b0; tick();
    check("zero_len_ignored", busy, 0);
    start = 1'b1; exp_bits = 10'd513; tick(); start = 1'b0; tick();
    check("over_len_ignored", busy, 0);
    b_done = ndone;
    abort = 1'b1; tick(); abort = 1'b0; tick();
    check("idle_abort", {busy, 8'(ndone - b_done)}, 0);
    run_nominal("nom");
    start_cap(10'd16);
    wait_en();
    wait_done(4100);
    check("nopre_rst_len", nrst - b_rst, 4);
    check("nopre_time", dcyc - en_cyc, 4000);
    check("nopre_err", derr, 1);
    check("nopre_rx_en", en_at_done, 0);
    check("nopre_vld", nvld - b_vld, 0);
    start_cap(10'd16);
    wait_en();
    repeat (3999) tick();
    pre_det = 1'b1; tick(); pre_det = 1'b0;
    check("pre_final_wins", {rx_en, 8'(ndone - b_done)}, 9'h100);
    send(2, 32'h2, 22);
    start = 1'b1; exp_bits = 10'd16; tick(); start = 1'b0;
    send(2, 32'h1, 22);
    bit_vld = 1'b1; bit_dat = 1'b1; abort = 1'b1;
    tick();
    bit_vld = 1'b0; abort = 1'b0;
    tick();
    check("abort_vld", nvld - b_vld, 4);
    check("abort_err", derr, 3);
    check("abort_done", ndone - b_done, 1);
    repeat (10) tick();
    check("recv_start_ignored", {busy, 8'(nrst - b_rst)}, 4);
    start_cap(10'd32);
    wait_en();
    preamble(20);
    send(10, 32'h2AA, 22);
    wait_done(600);
    check("gap_vld", nvld - b_vld, 10);
    check("gap_last", nlast - b_last, 0);
    check("gap_err", derr, 2);
    check("gap_time", dcyc - last_vld_cyc, 400);
    start_cap(10'd16);
    wait_en();
    preamble(5);
    send(3, 32'h5, 22);
    bit_vld = 1'b1; bit_dat = 1'b1;
    tick();
    bit_vld = 1'b0;
    check("mid_vld_before_rst", out_vld, 1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_outs", {rx_rst, rx_en, out_dat, out_vld, out_last, busy, done, err}, 0);
    repeat (3) tick();
    check("async_rst_no_done", ndone - b_done, 0);
    rst_n = 1'b1;
    tick();
    run_nominal("renom");
`ifdef RX_SEQ_CRC16_EN
    c = 16'hFFFF;
    for (int i = 0; i < 16; i++) c = crc_step(c, 1'b0);
    data = {16'h0000, ~c};
    start_cap(10'd32); wait_en(); preamble(10); send(32, data, 22); wait_done(100);
    check("crc_good_err", derr, 0);
    check("crc_good_ok", dcrc, 1);
    start_cap(10'd32); wait_en(); preamble(10); send(32, data ^ 32'h0001_0000, 22); wait_done(100);
    check("crc_bad_err", derr, 3);
    check("crc_bad_ok", dcrc, 0);
`else
    c = 16'h0;
    data = {16'h0, c};
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
